// File: rtl/bullet_engine.sv
// Single player bullet: spawns on a shoot edge, climbs one step per movement
// tick, and reports enemy head hits with a short cooldown before the next shot.
module bullet_engine #(
    parameter int STEP_DIV       = 500000,
    parameter int STEP_PX        = 4,
    parameter int BULLET_SIZE    = 10,
    parameter int TOP_LIMIT      = 11,
    parameter int COOLDOWN_TICKS = 8,
    parameter int PARK_X         = 700,
    parameter int PARK_Y         = 0
) (
    input  logic       master_clk,
    input  logic       resetn,
    input  logic       shoot,
    input  logic [9:0] player_x,
    input  logic [8:0] player_y,
    input  logic [9:0] enemy_x,
    input  logic [8:0] enemy_y,
    output logic [9:0] bullet_x,
    output logic [8:0] bullet_y,
    output logic       bullet_active,
    output logic       hit,
    output logic [7:0] hit_count
);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_DIV - 1);
    localparam logic [9:0]       PARK_XV   = 10'(PARK_X);
    localparam logic [8:0]       PARK_YV   = 9'(PARK_Y);
    localparam logic [9:0]       SIZE_X    = 10'(BULLET_SIZE);
    localparam logic [8:0]       SIZE_Y    = 9'(BULLET_SIZE);
    localparam logic [8:0]       STEP_Y    = 9'(STEP_PX);
    localparam logic [8:0]       SPAWN_MIN = 9'(TOP_LIMIT + BULLET_SIZE);
    localparam logic [8:0]       TOP_MOVE  = 9'(TOP_LIMIT + STEP_PX);
    localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(COOLDOWN_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLIGHT,
        S_HIT,
        S_COOLDOWN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [9:0]        bx_q, bx_d;
    logic [8:0]        by_q, by_d;
    logic              act_q, act_d;
    logic              hit_q, hit_d;
    logic [7:0]        hc_q, hc_d;
    logic              shoot_q;
    logic              armed_q;

    logic              tick;
    logic              fire_edge;
    logic [9:0]        dx;
    logic [8:0]        dy;

    // armed_q blocks the artificial edge seen when shoot is already high as reset releases
    assign fire_edge = shoot & ~shoot_q & armed_q;
    assign tick      = (cnt_q == CNT_LAST);
    assign cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    assign dx        = (bx_q >= enemy_x) ? (bx_q - enemy_x) : (enemy_x - bx_q);
    assign dy        = (by_q >= enemy_y) ? (by_q - enemy_y) : (enemy_y - by_q);

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        bx_d    = bx_q;
        by_d    = by_q;
        act_d   = act_q;
        hit_d   = 1'b0;
        hc_d    = hc_q;
        case (state_q)
            S_IDLE: begin
                if (fire_edge && (player_y >= SPAWN_MIN)) begin
                    bx_d    = player_x;
                    by_d    = player_y - SIZE_Y;
                    act_d   = 1'b1;
                    state_d = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (tick) begin
                    if ((dx < SIZE_X) && (dy < SIZE_Y)) begin
                        hit_d   = 1'b1;
                        hc_d    = (hc_q == 8'hFF) ? hc_q : hc_q + 8'd1;
                        bx_d    = PARK_XV;
                        by_d    = PARK_YV;
                        act_d   = 1'b0;
                        cd_d    = CD_LOAD;
                        state_d = S_HIT;
                    end else if (by_q < TOP_MOVE) begin
                        bx_d    = PARK_XV;
                        by_d    = PARK_YV;
                        act_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        by_d = by_q - STEP_Y;
                    end
                end
            end
            S_HIT: begin
                state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (tick) begin
                    if (cd_q <= CD_W'(1)) begin
                        cd_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge master_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cd_q    <= '0;
            bx_q    <= PARK_XV;
            by_q    <= PARK_YV;
            act_q   <= 1'b0;
            hit_q   <= 1'b0;
            hc_q    <= 8'd0;
            shoot_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cd_q    <= cd_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            hc_q    <= hc_d;
            shoot_q <= shoot;
            armed_q <= 1'b1;
        end
    end

    assign bullet_x      = bx_q;
    assign bullet_y      = by_q;
    assign bullet_active = act_q;
    assign hit           = hit_q;
    assign hit_count     = hc_q;
endmodule
